// File: rtl/ahb_to_apb_bridge_mc_if.sv
// AHB-Lite slave side and multi-completer APB side of the bridge,
// bundled so the bridge and its environment share one port list.
interface ahb_to_apb_bridge_mc_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic                             HSEL;
    logic [ADDR_WIDTH-1:0]            HADDR;
    logic [1:0]                       HTRANS;
    logic                             HWRITE;
    logic                             HREADY_IN;
    logic [DATA_WIDTH-1:0]            HWDATA;
    logic [DATA_WIDTH-1:0]            HRDATA;
    logic                             HREADY_OUT;
    logic                             HRESP;
    logic [NUM_SLAVES-1:0]            PSEL;
    logic                             PENABLE;
    logic [ADDR_WIDTH-1:0]            PADDR;
    logic                             PWRITE;
    logic [DATA_WIDTH-1:0]            PWDATA;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]            PREADY;
    logic [NUM_SLAVES-1:0]            PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY_IN, HWDATA,
        input  PRDATA, PREADY, PSLVERR,
        output HRDATA, HREADY_OUT, HRESP,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY_IN, HWDATA,
        output PRDATA, PREADY, PSLVERR,
        input  HRDATA, HREADY_OUT, HRESP,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/ahb_to_apb_bridge_mc.sv
// AHB-Lite to multi-completer APB3 bridge with wait states,
// PSLVERR and PREADY-timeout errors and a two-cycle AHB ERROR.
module ahb_to_apb_bridge_mc #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                   HCLK,
    input logic                   HRESETn,
    ahb_to_apb_bridge_mc_if.slave bus
);
    localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

    typedef enum logic [2:0] {
        IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic [NUM_SLAVES-1:0] tgt_q, tgt_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic                  hresp_q, hresp_d;
    logic                  hready_q, hready_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [IDXW-1:0]       idx;
    logic [NUM_SLAVES-1:0] onehot;
    logic                  accept;
    logic                  in_range;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  unused_htrans0;

    assign unused_htrans0 = bus.HTRANS[0];

    // Only the selected completer's response lines are observed.
    always_comb begin
        idx       = bus.HADDR[SEL_LSB +: IDXW];
        onehot    = SEL_ONE << idx;
        in_range  = int'(idx) < NUM_SLAVES;
        accept    = bus.HSEL & bus.HTRANS[1] & bus.HREADY_IN & hready_q;
        sel_ready = |(bus.PREADY & psel_q);
        sel_err   = |(bus.PSLVERR & psel_q);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_q[i]) begin
                sel_rdata = sel_rdata | bus.PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        tgt_d     = tgt_q;
        penable_d = 1'b0;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        hrdata_d  = hrdata_q;
        hresp_d   = 1'b0;
        hready_d  = 1'b1;
        cnt_d     = '0;
        unique case (state_q)
            IDLE, ERR2: begin
                state_d = IDLE;
                psel_d  = '0;
                if (accept) begin
                    tgt_d    = onehot;
                    hready_d = 1'b0;
                    if (!in_range) begin
                        state_d = ERR1;
                        hresp_d = 1'b1;
                    end else begin
                        paddr_d  = bus.HADDR;
                        pwrite_d = bus.HWRITE;
                        if (bus.HWRITE) begin
                            state_d = WDATA;
                        end else begin
                            state_d = SETUP;
                            psel_d  = onehot;
                        end
                    end
                end
            end
            WDATA: begin
                state_d  = SETUP;
                psel_d   = tgt_q;
                pwdata_d = bus.HWDATA;
                hready_d = 1'b0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                hready_d  = 1'b0;
            end
            ACCESS: begin
                cnt_d     = cnt_q + CW'(1);
                penable_d = 1'b1;
                hready_d  = 1'b0;
                if (sel_ready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (sel_err) begin
                        state_d = ERR1;
                        hresp_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        hready_d = 1'b1;
                        if (!pwrite_q) hrdata_d = sel_rdata;
                    end
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ERR1;
                    hresp_d   = 1'b1;
                end
            end
            ERR1: begin
                state_d = ERR2;
                psel_d  = '0;
                hresp_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                psel_d  = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            psel_q    <= '0;
            tgt_q     <= '0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
            hresp_q   <= 1'b0;
            hready_q  <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            tgt_q     <= tgt_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            hrdata_q  <= hrdata_d;
            hresp_q   <= hresp_d;
            hready_q  <= hready_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.PSEL       = psel_q;
    assign bus.PENABLE    = penable_q;
    assign bus.PADDR      = paddr_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PWDATA     = pwdata_q;
    assign bus.HRDATA     = hrdata_q;
    assign bus.HRESP      = hresp_q;
    assign bus.HREADY_OUT = hready_q;
endmodule

// File: tb/tb_ahb_to_apb_bridge_mc.sv
// Scoreboard bench for the AHB-to-APB bridge: four APB completer
// models with per-completer wait states, PSLVERR and hang controls.
module tb_ahb_to_apb_bridge_mc;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_to_apb_bridge_mc_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)
    ) bus ();

    ahb_to_apb_bridge_mc #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
        .SEL_LSB(12), .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK(clk),
        .HRESETn(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } ahb_exp_t;

    typedef struct {
        logic [3:0]  psel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          en;
    } apb_exp_t;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];
    int compared = 0;
    int mismatched = 0;

    logic [31:0] mem [NS][64];
    int wait_n [NS];
    bit err_n [NS];
    bit hang [NS];
    int wcnt [NS];
    logic [31:0] prev_wd = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: bound expired, got timeout expected event", name);
    endtask

    // Completer models
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            bus.PREADY[i]  = bus.PSEL[i] & bus.PENABLE & !hang[i]
                             & (wcnt[i] >= wait_n[i]);
            bus.PSLVERR[i] = bus.PSEL[i] & bus.PENABLE & !hang[i]
                             & (wcnt[i] >= wait_n[i]) & err_n[i];
            bus.PRDATA[i*DW +: DW] = mem[i][bus.PADDR[7:2]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst_n) begin
                wcnt[i] <= 0;
            end else if (bus.PSEL[i] && bus.PENABLE && !bus.PREADY[i]) begin
                wcnt[i] <= wcnt[i] + 1;
            end else begin
                wcnt[i] <= 0;
            end
            if (!rst_n) begin
                for (int j = 0; j < 64; j++) begin
                    mem[i][j] <= 32'hA000_0000 | (i << 8) | j;
                end
            end else if (bus.PSEL[i] && bus.PENABLE && bus.PREADY[i]
                         && bus.PWRITE && !bus.PSLVERR[i]) begin
                mem[i][bus.PADDR[7:2]] <= bus.PWDATA;
            end
        end
    end

    // AHB response monitor
    initial begin
        bit pend;
        bit done;
        bit errlow;
        int lowcnt;
        ahb_exp_t e;
        pend = 0;
        errlow = 0;
        lowcnt = 0;
        forever begin
            @(negedge clk);
            done = 0;
            if (!rst_n) begin
                pend = 0;
                lowcnt = 0;
                errlow = 0;
            end else begin
                if (pend) begin
                    if (!bus.HREADY_OUT) begin
                        lowcnt++;
                        if (bus.HRESP) errlow = 1;
                    end else begin
                        done = 1;
                        check("ahb_expected_present", ahb_q.size() > 0, 1);
                        if (ahb_q.size() > 0) begin
                            e = ahb_q.pop_front();
                            check("ahb_wait_cycles", lowcnt, e.lat);
                            check("ahb_hresp", {errlow, bus.HRESP},
                                  {e.err, e.err});
                            if (!e.wr) check("ahb_hrdata", bus.HRDATA, e.rdata);
                        end
                        lowcnt = 0;
                        errlow = 0;
                    end
                end
                if (bus.HSEL && bus.HTRANS[1] && bus.HREADY_IN
                    && bus.HREADY_OUT) begin
                    pend = 1;
                end else if (done) begin
                    pend = 0;
                end
            end
        end
    end

    task automatic apb_cmp(input logic [3:0] s, input logic [31:0] a,
                           input logic w, input logic [31:0] d, input int en);
        apb_exp_t e;
        check("apb_expected_present", apb_q.size() > 0, 1);
        if (apb_q.size() > 0) begin
            e = apb_q.pop_front();
            check("apb_psel", s, e.psel);
            check("apb_paddr", a, e.addr);
            check("apb_pwrite", w, e.wr);
            if (e.wr) check("apb_pwdata", d, e.wdata);
            check("apb_penable_cycles", en, e.en);
        end
    endtask

    // APB access monitor: one event per completed or aborted access
    initial begin
        int en;
        bit act;
        logic [3:0] s;
        logic [31:0] a;
        logic [31:0] d;
        logic w;
        en = 0;
        act = 0;
        s = '0;
        a = '0;
        d = '0;
        w = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en = 0;
                act = 0;
            end else if (bus.PENABLE) begin
                en++;
                act = 1;
                s = bus.PSEL;
                a = bus.PADDR;
                w = bus.PWRITE;
                d = bus.PWDATA;
                if ((bus.PREADY & bus.PSEL) != 0) begin
                    apb_cmp(s, a, w, d, en);
                    en = 0;
                    act = 0;
                end
            end else if (act) begin
                apb_cmp(s, a, w, d, en);
                en = 0;
                act = 0;
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic err,
                        input logic [31:0] rd, input int lat,
                        input logic [3:0] psel, input int en,
                        input bit push);
        ahb_exp_t ae;
        apb_exp_t pe;
        bit rdy;
        int n;
        if (push) begin
            ae.wr = w; ae.err = err; ae.rdata = rd; ae.lat = lat;
            ahb_q.push_back(ae);
            pe.psel = psel; pe.addr = a; pe.wr = w; pe.wdata = wd; pe.en = en;
            apb_q.push_back(pe);
        end
        bus.HSEL = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR = a;
        bus.HWRITE = w;
        bus.HWDATA = prev_wd;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = bus.HREADY_OUT;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 100) begin
                fail_bound("accept_wait");
                break;
            end
        end
        if (w) prev_wd = wd;
    endtask

    task automatic go_idle();
        int n;
        bus.HSEL = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = prev_wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (ahb_q.size() == 0 && apb_q.size() == 0) break;
            n++;
            if (n > 200) begin
                fail_bound("drain_wait");
                ahb_q.delete();
                apb_q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_psel"}, bus.PSEL, 0);
        check({tag, "_penable"}, bus.PENABLE, 0);
        check({tag, "_paddr"}, bus.PADDR, 0);
        check({tag, "_pwrite"}, bus.PWRITE, 0);
        check({tag, "_pwdata"}, bus.PWDATA, 0);
        check({tag, "_hrdata"}, bus.HRDATA, 0);
        check({tag, "_hresp"}, bus.HRESP, 0);
        check({tag, "_hready_out"}, bus.HREADY_OUT, 1);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            wait_n[i] = 0;
            err_n[i] = 0;
            hang[i] = 0;
        end
        bus.HSEL = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR = '0;
        bus.HWRITE = 1'b0;
        bus.HWDATA = '0;
        bus.HREADY_IN = 1'b1;

        #12;
        check_reset_vals("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read completer 1
        xfer(32'h0000_1004, 1, 32'hBEEF_BEEF, 0, 32'h0, 3, 4'b0010, 1, 1);
        xfer(32'h0000_1004, 0, 32'h0, 0, 32'hBEEF_BEEF, 2, 4'b0010, 1, 1);
        go_idle();

        // Five PREADY wait states on completer 3
        wait_n[3] = 5;
        xfer(32'h0000_3008, 0, 32'h0, 0, 32'hA000_0302, 7, 4'b1000, 6, 1);
        go_idle();
        wait_n[3] = 0;

        // Pipelined writes to completers 0 and 2, then read back
        xfer(32'h0000_0010, 1, 32'h1234, 0, 32'h0, 3, 4'b0001, 1, 1);
        xfer(32'h0000_2014, 1, 32'h4321, 0, 32'h0, 3, 4'b0100, 1, 1);
        xfer(32'h0000_0010, 0, 32'h0, 0, 32'h1234, 2, 4'b0001, 1, 1);
        xfer(32'h0000_2014, 0, 32'h0, 0, 32'h4321, 2, 4'b0100, 1, 1);
        go_idle();

        // PSLVERR read: ERROR response, HRDATA keeps 0x4321
        err_n[2] = 1;
        xfer(32'h0000_2018, 0, 32'h0, 1, 32'h4321, 3, 4'b0100, 1, 1);
        go_idle();
        err_n[2] = 0;

        // Completer 0 hangs: 16 ACCESS cycles then ERROR; next read OKAY
        hang[0] = 1;
        xfer(32'h0000_0000, 0, 32'h0, 1, 32'h4321, 18, 4'b0001, 16, 1);
        xfer(32'h0000_1004, 0, 32'h0, 0, 32'hBEEF_BEEF, 2, 4'b0010, 1, 1);
        go_idle();
        hang[0] = 0;

        // Reset pulsed while completer 1 stalls in ACCESS
        hang[1] = 1;
        xfer(32'h0000_1008, 0, 32'h0, 0, 32'h0, 0, 4'b0010, 0, 0);
        bus.HSEL = 1'b0;
        bus.HTRANS = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_penable", bus.PENABLE, 1);
        check("pre_reset_psel", bus.PSEL, 4'b0010);
        check("pre_reset_hready_out", bus.HREADY_OUT, 0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hang[1] = 0;

        // NONSEQ without HSEL is ignored
        bus.HSEL = 1'b0;
        bus.HTRANS = 2'b10;
        bus.HADDR = 32'h0000_1004;
        bus.HWRITE = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("unselected_psel", bus.PSEL, 0);
            check("unselected_hready_out", bus.HREADY_OUT, 1);
        end
        bus.HTRANS = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        check("ahb_queue_drained", ahb_q.size(), 0);
        check("apb_queue_drained", apb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ahb_to_apb_bridge_mc.md
Name: ahb_to_apb_bridge_mc

Overview:
Parametrised successor to the single-completer AHB-to-APB bridge. It is an AHB-Lite slave that fans out to NUM_SLAVES APB completers, decoding the target from address bits. It adds APB3 PREADY wait states and PSLVERR, a PREADY timeout, and a two-cycle AHB ERROR response. PCLK is HCLK, so the bridge has one clock.

Parameters:
ADDR_WIDTH, 32, AHB/APB address width
DATA_WIDTH, 32, data bus width
NUM_SLAVES, 4, number of APB completers (1..16)
SEL_LSB, 12, lowest HADDR bit of the completer index field; field width IDXW = max(1, clog2(NUM_SLAVES))
TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before error; 0 disables the timeout

Ports:
HCLK  in  1  clock; the APB side also runs on it
HRESETn  in  1  reset, asynchronous, active-low
HSEL  in  1  bridge select
HADDR  in  ADDR_WIDTH  address-phase address
HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
HWRITE  in  1  1=write
HREADY_IN  in  1  bus-level HREADY
HWDATA  in  DATA_WIDTH  write data, valid in the data phase
HRDATA  out  DATA_WIDTH  read data
HREADY_OUT  out  1  bridge ready
HRESP  out  1  0=OKAY, 1=ERROR
PSEL  out  NUM_SLAVES  one-hot completer select
PENABLE  out  1  APB access phase
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  NUM_SLAVES*DATA_WIDTH  flattened read data; completer i occupies [i*DATA_WIDTH +: DATA_WIDTH]
PREADY  in  NUM_SLAVES  per-completer ready
PSLVERR  in  NUM_SLAVES  per-completer error

Behaviour:
- Reset (async assert, sync release):
  - outputs: PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, HRDATA=0, HRESP=0, HREADY_OUT=1
  - FSM goes to IDLE; timeout counter cleared
  - reset mid-transfer aborts immediately; no completion is reported
- Transfer accept: at a rising edge where HSEL & HTRANS[1] & HREADY_IN & HREADY_OUT=1.
  - latch HADDR, HWRITE and idx = HADDR[SEL_LSB +: IDXW]
  - anything else (IDLE/BUSY, HSEL=0, HREADY_IN=0) is ignored: no APB activity, HREADY_OUT=1, HRESP=0
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: HREADY_OUT=1. On accept: idx>=NUM_SLAVES -> ERR1; write -> WDATA; read -> SETUP.
  - WDATA: HREADY_OUT=0; capture HWDATA into PWDATA at end of cycle -> SETUP.
  - SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE valid, HREADY_OUT=0 -> ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1, HREADY_OUT=0; counter increments each cycle.
    - PREADY[idx]=1 & PSLVERR[idx]=0 -> IDLE; PSEL/PENABLE drop; HREADY_OUT=1 next cycle; on reads HRDATA <= PRDATA slice idx, registered.
    - PREADY[idx]=1 & PSLVERR[idx]=1 -> ERR1; HRDATA is not updated.
    - TIMEOUT_CYCLES>0, counter reaches TIMEOUT_CYCLES with PREADY[idx]=0 -> drop PSEL/PENABLE -> ERR1.
  - ERR1: HRESP=1, HREADY_OUT=0 -> ERR2.
  - ERR2: HRESP=1, HREADY_OUT=1 -> IDLE. A valid transfer presented in ERR2 is accepted at that edge (same rule as IDLE) and goes to WDATA/SETUP/ERR1 directly.
- Pipelining: the next address phase overlaps the completing data phase. A transfer present when HREADY_OUT=1 is accepted at that edge, so back-to-back transfers have no idle cycle.
- Latency with zero-wait completers (accept edge E0):
  - read: HREADY_OUT low for 2 cycles; data returned in cycle 3
  - write: HREADY_OUT low for 3 cycles
  - each PREADY wait state adds 1 cycle
- Signal holding rules:
  - PSEL is always one-hot or zero; only one completer is active at a time.
  - PADDR, PWRITE and PWDATA hold their last values when idle.
  - HRDATA holds the last successful read; writes and errors leave it unchanged.
  - PREADY/PSLVERR/PRDATA of non-selected completers are ignored.
- Out-of-range idx (only possible when NUM_SLAVES is not a power of 2): ERROR response with no PSEL asserted.

Test Plan:
- Write 0xBEEF_BEEF to 0x0000_1004, then read 0x0000_1004, completer 1 zero-wait -> PSEL=4'b0010; HREADY_OUT low 3 then 2 cycles; HRDATA=0xBEEF_BEEF, HRESP=0.
- Read 0x0000_3008 with completer 3 holding PREADY low for 5 cycles -> PENABLE high 6 cycles; HREADY_OUT low 7 cycles; data correct.
- Pipelined writes 0x0000_0010=0x1234, 0x0000_2014=0x4321, second address driven in first data phase -> two APB writes to completers 0 and 2 with no idle cycle between; memories hold both values.
- Read with PSLVERR[2]=1 on completion -> ERR1 (HRESP=1, HREADY_OUT=0), then ERR2 (HRESP=1, HREADY_OUT=1); HRDATA unchanged from the prior value.
- TIMEOUT_CYCLES=16, completer 0 never asserts PREADY -> PSEL/PENABLE drop after 16 ACCESS cycles, then ERROR response; the next transfer to completer 1 completes OKAY.
- HRESETn pulsed low during ACCESS -> all outputs at reset values immediately; HSEL=0 with HTRANS=NONSEQ produces no PSEL.
